// File: rtl/l1d_line_axi_master.sv
// ============================================================================
// Module   : l1d_line_axi_master
// Purpose  : L1D line-granular AXI initiator (refill read / writeback write).
//            Optional watchdog enabled by L1D_LINE_AXI_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l1d_line_axi_master #(
  parameter int DATA_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [ID_WIDTH-1:0]           req_id,
  input  logic [DATA_WIDTH-1:0]         req_data,
  input  logic [DATA_WIDTH/8-1:0]       req_mask,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_rw,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [ADDR_WIDTH-1:0]         araddr,
  output logic [ID_WIDTH-1:0]           arid,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic [ID_WIDTH-1:0]           awid,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [AXI_DATA_WIDTH-1:0]     wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  output logic                          wlast,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [AXI_DATA_WIDTH-1:0]     rdata,
  input  logic [ID_WIDTH-1:0]           rid,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [ID_WIDTH-1:0]           bid,
  input  logic [1:0]                    bresp
);

  localparam int N_BEATS      = DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int STRB_W       = AXI_DATA_WIDTH / 8;
  localparam int BEAT_W       = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(N_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(DATA_WIDTH / 8 - 1));

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]                r_state;
  logic                      r_req_ready, r_resp_valid, r_rw, r_err;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [ID_WIDTH-1:0]       r_id;
  logic [DATA_WIDTH-1:0]     r_line;
  logic [DATA_WIDTH/8-1:0]   r_mask;
  logic [BEAT_W-1:0]         r_beat;
  logic                      r_arvalid, r_awvalid, r_wvalid, r_wlast, r_rready, r_bready;
  logic                      r_aw_done, r_w_done;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;

  logic              w_last_beat, w_aw_fire, w_w_fire, w_r_fire, w_timeout;
  logic [BEAT_W-1:0] w_beat_nxt;

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_nxt  = r_beat + BEAT_W'(1);
  assign w_aw_fire   = r_awvalid & awready;
  assign w_w_fire    = r_wvalid & wready;
  assign w_r_fire    = r_rready & rvalid;

`ifdef L1D_LINE_AXI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             w_any_hs;

  // Every state entry coincides with a handshake, so clearing on handshakes covers entries too.
  assign w_any_hs = (r_arvalid & arready) | w_aw_fire | w_w_fire | w_r_fire | (r_bready & bvalid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_tmo <= '0;
    else if (r_state == S_IDLE || r_state == S_RESP || w_any_hs)
      r_tmo <= '0;
    else
      r_tmo <= r_tmo + TMO_W'(1);
  end

  assign w_timeout = (r_state != S_IDLE) && (r_state != S_RESP) && !w_any_hs &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the block waits indefinitely; TIMEOUT_CYCLES is inert.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rw         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_id         <= '0;
      r_line       <= '0;
      r_mask       <= '0;
      r_beat       <= '0;
      r_arvalid    <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_rready     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_rw        <= req_rw;
            r_addr      <= req_addr & ADDR_MASK;
            r_id        <= req_id;
            r_mask      <= req_mask;
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_line      <= req_rw ? req_data : '0;
            if (req_rw) begin
              r_state   <= S_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_wdata   <= req_data[AXI_DATA_WIDTH-1:0];
              r_wstrb   <= req_mask[STRB_W-1:0];
              r_wlast   <= (N_BEATS == 1);
            end else begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_r_fire) begin
            r_line[r_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= rdata;
            if (rresp != 2'b00 || rid != r_id || rlast != w_last_beat)
              r_err <= 1'b1;
            if (w_last_beat) begin
              r_rready     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_beat <= w_beat_nxt;
            end
          end
        end
        S_WR: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_w_done <= 1'b1;
            end else begin
              r_beat  <= w_beat_nxt;
              r_wdata <= r_line[w_beat_nxt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
              r_wstrb <= r_mask[w_beat_nxt*STRB_W +: STRB_W];
              r_wlast <= (w_beat_nxt == LAST_BEAT);
            end
          end
          if ((r_aw_done || w_aw_fire) && (r_w_done || (w_w_fire && r_wlast))) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            if (bresp != 2'b00 || bid != r_id)
              r_err <= 1'b1;
            r_bready     <= 1'b0;
            r_line       <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_arvalid    <= 1'b0;
        r_awvalid    <= 1'b0;
        r_wvalid     <= 1'b0;
        r_wlast      <= 1'b0;
        r_rready     <= 1'b0;
        r_bready     <= 1'b0;
        r_err        <= 1'b1;
        r_line       <= '0;
        r_resp_valid <= 1'b1;
        r_state      <= S_RESP;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rw    = r_rw;
  assign resp_id    = r_id;
  assign resp_data  = r_line;
  assign resp_err   = r_err;
  assign arvalid    = r_arvalid;
  assign araddr     = r_addr;
  assign arid       = r_id;
  assign awvalid    = r_awvalid;
  assign awaddr     = r_addr;
  assign awid       = r_id;
  assign wvalid     = r_wvalid;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign wlast      = r_wlast;
  assign rready     = r_rready;
  assign bready     = r_bready;

endmodule

`default_nettype wire
